// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the memory stage.
//   MTR_*             : mem_to_reg result-select encodings
//   mem_stage_state_t : load-stall FSM states
//   ex_mem_t          : contents of the EX/MEM pipeline register
package pipeline_pkg;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_LOAD = 2'b01;
  localparam logic [1:0] MTR_PC4  = 2'b10;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_stage_state_t;

  typedef struct packed {
    logic [31:0] alu_to_mem;
    logic [31:0] store_data;
    logic [4:0]  wr_reg_addr;
    logic        wr_reg_en;
    logic [1:0]  mem_to_reg;
    logic        mem_wr;
    logic        sign_zero_ext;
    logic        store_hb;
    logic        hb_sel;
    logic        link;
    logic [31:0] pc4;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        hi_wr_en;
    logic        lo_wr_en;
  } ex_mem_t;

endpackage

// File: rtl/memory_stage_if.sv
// Bundle of all memory-stage signals except clock and reset.
//   slave  : used by memory_stage (EX-side fields in, MEM/WB and forwarding taps out)
//   master : used by the upstream driver
// With MEM_ALIGN_CHECK_EN defined the bundle also carries misalign_trap.
interface memory_stage_if;

  logic [31:0] alu_to_mem;
  logic [31:0] store_data_ex;
  logic [4:0]  wr_reg_addr_ex;
  logic        wr_reg_en_ex;
  logic [1:0]  mem_to_reg_ex;
  logic        mem_wr_ex;
  logic        sign_zero_ext_ex;
  logic        store_hb_ex;
  logic        hb_sel_ex;
  logic        link_ex;
  logic [31:0] PC4_ex;
  logic [31:0] res_hi_to_mem;
  logic [31:0] res_lo_to_mem;
  logic        hi_wr_en_ex;
  logic        lo_wr_en_ex;

  logic [31:0] res_mem;
  logic [4:0]  mem_dst;
  logic        mem_reg_wr;
  logic [31:0] res_wb;
  logic [4:0]  wb_dst;
  logic        wb_reg_wr;
  logic [31:0] PC4_wb;
  logic [31:0] res_hi_wb;
  logic [31:0] res_lo_wb;
  logic        link_wb;
  logic        hi_wr_en_wb;
  logic        lo_wr_en_wb;
  logic        mem_stall;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_trap;
`endif

  modport slave (
    input  alu_to_mem, store_data_ex, wr_reg_addr_ex, wr_reg_en_ex, mem_to_reg_ex, mem_wr_ex,
           sign_zero_ext_ex, store_hb_ex, hb_sel_ex, link_ex, PC4_ex, res_hi_to_mem,
           res_lo_to_mem, hi_wr_en_ex, lo_wr_en_ex,
    output res_mem, mem_dst, mem_reg_wr, res_wb, wb_dst, wb_reg_wr, PC4_wb, res_hi_wb,
           res_lo_wb, link_wb, hi_wr_en_wb, lo_wr_en_wb, mem_stall
`ifdef MEM_ALIGN_CHECK_EN
    , output misalign_trap
`endif
  );

  modport master (
    output alu_to_mem, store_data_ex, wr_reg_addr_ex, wr_reg_en_ex, mem_to_reg_ex, mem_wr_ex,
           sign_zero_ext_ex, store_hb_ex, hb_sel_ex, link_ex, PC4_ex, res_hi_to_mem,
           res_lo_to_mem, hi_wr_en_ex, lo_wr_en_ex,
    input  res_mem, mem_dst, mem_reg_wr, res_wb, wb_dst, wb_reg_wr, PC4_wb, res_hi_wb,
           res_lo_wb, link_wb, hi_wr_en_wb, lo_wr_en_wb, mem_stall
`ifdef MEM_ALIGN_CHECK_EN
    , input misalign_trap
`endif
  );

endinterface

// File: rtl/memory_stage_data_memory.sv
// data_memory: byte-enabled RAM, synchronous write, asynchronous read. Not reset.
//   clk_i   : write clock
//   we_i    : write enable
//   be_i    : byte enables (bit n writes wdata_i[8n+7:8n])
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data at addr_i (combinational)
module data_memory #(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [3:0]                    be_i,
  input  logic [$clog2(DMEM_WORDS)-1:0] addr_i,
  input  logic [31:0]                   wdata_i,
  output logic [31:0]                   rdata_o
);

  logic [31:0] mem_q [DMEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, data-memory load/store with sub-word extract and
// extension, writeback result select, MEM/WB register, and a load-latency stall FSM.
//   clk, reset : clock, synchronous active-high reset
//   bus        : memory_stage_if.slave (EX inputs, forwarding taps, MEM/WB outputs,
//                combinational mem_stall)
// Optional macro MEM_ALIGN_CHECK_EN adds bus.misalign_trap and suppresses misaligned
// stores/register writes.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DMEM_WORDS   = 1024,
  parameter int unsigned LOAD_LATENCY = 2
) (
  input logic           clk,
  input logic           reset,
  memory_stage_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DMEM_WORDS);
  localparam int unsigned CntW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;

  ex_mem_t          ex_mem_d, ex_mem_q;
  mem_stage_state_t state_d, state_q;
  logic [CntW-1:0]  cnt_d, cnt_q;
  logic             stall;
  logic             is_load;
  logic             size_word, size_half;
  logic [1:0]       lane;
  logic             misalign;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata, mem_rdata;
  logic [15:0]      ld_half;
  logic [7:0]       ld_byte;
  logic [31:0]      load_data, result;

  // EX/MEM register
  always_comb begin
    ex_mem_d               = '0;
    ex_mem_d.alu_to_mem    = bus.alu_to_mem;
    ex_mem_d.store_data    = bus.store_data_ex;
    ex_mem_d.wr_reg_addr   = bus.wr_reg_addr_ex;
    ex_mem_d.wr_reg_en     = bus.wr_reg_en_ex;
    ex_mem_d.mem_to_reg    = bus.mem_to_reg_ex;
    ex_mem_d.mem_wr        = bus.mem_wr_ex;
    ex_mem_d.sign_zero_ext = bus.sign_zero_ext_ex;
    ex_mem_d.store_hb      = bus.store_hb_ex;
    ex_mem_d.hb_sel        = bus.hb_sel_ex;
    ex_mem_d.link          = bus.link_ex;
    ex_mem_d.pc4           = bus.PC4_ex;
    ex_mem_d.res_hi        = bus.res_hi_to_mem;
    ex_mem_d.res_lo        = bus.res_lo_to_mem;
    ex_mem_d.hi_wr_en      = bus.hi_wr_en_ex;
    ex_mem_d.lo_wr_en      = bus.lo_wr_en_ex;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q <= '0;
    end else if (!stall) begin
      ex_mem_q <= ex_mem_d;
    end
  end

  // Load-latency FSM: a load occupies MEM for LOAD_LATENCY cycles, the last of which
  // releases the stall so the following instruction advances on the same edge.
  assign is_load = (ex_mem_q.mem_to_reg == MTR_LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (LOAD_LATENCY > 1) begin
      case (state_q)
        IDLE: begin
          if (is_load) begin
            state_d = WAIT;
            cnt_d   = CntW'(LOAD_LATENCY - 1);
            stall   = 1'b1;
          end
        end
        WAIT: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access size and lane decode
  assign size_word = ~ex_mem_q.store_hb;
  assign size_half = ex_mem_q.store_hb & ex_mem_q.hb_sel;
  assign lane      = ex_mem_q.alu_to_mem[1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (is_load | ex_mem_q.mem_wr) &
                    ((size_word & (lane != 2'b00)) | (size_half & lane[0]));
`else
  assign misalign = 1'b0;
`endif

  // Store lane steering: sub-word data is replicated so the byte enables pick the lane.
  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = ex_mem_q.store_data;
    if (size_word) begin
      mem_be = 4'b1111;
    end else if (size_half) begin
      mem_be    = lane[1] ? 4'b1100 : 4'b0011;
      mem_wdata = {2{ex_mem_q.store_data[15:0]}};
    end else begin
      mem_be    = 4'b0001 << lane;
      mem_wdata = {4{ex_mem_q.store_data[7:0]}};
    end
  end

  assign mem_we = ex_mem_q.mem_wr & (state_q != WAIT) & ~misalign;

  data_memory #(
    .DMEM_WORDS(DMEM_WORDS)
  ) u_data_memory (
    .clk_i  (clk),
    .we_i   (mem_we),
    .be_i   (mem_be),
    .addr_i (ex_mem_q.alu_to_mem[IdxW+1:2]),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  // Load extract and extension
  assign ld_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ld_byte = mem_rdata[{lane, 3'b000} +: 8];

  always_comb begin
    load_data = mem_rdata;
    if (size_half) begin
      load_data = {{16{ex_mem_q.sign_zero_ext & ld_half[15]}}, ld_half};
    end else if (!size_word) begin
      load_data = {{24{ex_mem_q.sign_zero_ext & ld_byte[7]}}, ld_byte};
    end
  end

  // Writeback result select; link overrides mem_to_reg
  always_comb begin
    result = ex_mem_q.alu_to_mem;
    if (ex_mem_q.link) begin
      result = ex_mem_q.pc4;
    end else begin
      case (ex_mem_q.mem_to_reg)
        MTR_LOAD: result = load_data;
        MTR_PC4:  result = ex_mem_q.pc4;
        default:  result = ex_mem_q.alu_to_mem;
      endcase
    end
  end

  // MEM/WB register; while stalled, the enables are cleared to form a bubble
  logic [31:0] res_wb_q, pc4_wb_q, res_hi_wb_q, res_lo_wb_q;
  logic [4:0]  wb_dst_q;
  logic        wb_reg_wr_q, link_wb_q, hi_wr_en_wb_q, lo_wr_en_wb_q, trap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_wb_q      <= '0;
      wb_dst_q      <= '0;
      wb_reg_wr_q   <= 1'b0;
      pc4_wb_q      <= '0;
      res_hi_wb_q   <= '0;
      res_lo_wb_q   <= '0;
      link_wb_q     <= 1'b0;
      hi_wr_en_wb_q <= 1'b0;
      lo_wr_en_wb_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      res_wb_q      <= result;
      wb_dst_q      <= ex_mem_q.wr_reg_addr;
      wb_reg_wr_q   <= ex_mem_q.wr_reg_en & ~stall & ~misalign;
      pc4_wb_q      <= ex_mem_q.pc4;
      res_hi_wb_q   <= ex_mem_q.res_hi;
      res_lo_wb_q   <= ex_mem_q.res_lo;
      link_wb_q     <= ex_mem_q.link;
      hi_wr_en_wb_q <= ex_mem_q.hi_wr_en & ~stall;
      lo_wr_en_wb_q <= ex_mem_q.lo_wr_en & ~stall;
      trap_q        <= misalign & ~stall;
    end
  end

  assign bus.res_mem     = ex_mem_q.alu_to_mem;
  assign bus.mem_dst     = ex_mem_q.wr_reg_addr;
  assign bus.mem_reg_wr  = ex_mem_q.wr_reg_en;
  assign bus.res_wb      = res_wb_q;
  assign bus.wb_dst      = wb_dst_q;
  assign bus.wb_reg_wr   = wb_reg_wr_q;
  assign bus.PC4_wb      = pc4_wb_q;
  assign bus.res_hi_wb   = res_hi_wb_q;
  assign bus.res_lo_wb   = res_lo_wb_q;
  assign bus.link_wb     = link_wb_q;
  assign bus.hi_wr_en_wb = hi_wr_en_wb_q;
  assign bus.lo_wr_en_wb = lo_wr_en_wb_q;
  assign bus.mem_stall   = stall;
`ifdef MEM_ALIGN_CHECK_EN
  assign bus.misalign_trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of Execute. Registers the EX/MEM boundary and performs data-memory loads and stores (word, halfword, byte), with sign or zero extension on loads.
- Selects the writeback result and registers the MEM/WB boundary.
- Drives the forwarding taps (res_mem/mem_dst/mem_reg_wr, res_wb/wb_dst/wb_reg_wr) that Decode and Execute consume.
- Holds the pipeline for a parameterised number of cycles on loads.

Parameters:
- DMEM_WORDS, 1024, data memory depth in 32-bit words; the address index is $clog2(DMEM_WORDS) bits.
- LOAD_LATENCY, 2, cycles from load entering MEM until data is valid (>=1); 1 means no stall.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_to_mem  in  32  EX result / effective byte address
- store_data_ex  in  32  rt value to store
- wr_reg_addr_ex  in  5  destination register
- wr_reg_en_ex  in  1  register write enable
- mem_to_reg_ex  in  2  result select: 00 ALU, 01 load, 10 PC4 (link), 11 reserved (treated as ALU)
- mem_wr_ex  in  1  store enable
- sign_zero_ext_ex  in  1  load extension: 1 sign, 0 zero
- store_hb_ex  in  1  sub-word access
- hb_sel_ex  in  1  when store_hb_ex=1: 1 halfword, 0 byte
- link_ex  in  1  link instruction
- PC4_ex  in  32  PC+4 of the instruction
- res_hi_to_mem, res_lo_to_mem  in  32 each  HI/LO results
- hi_wr_en_ex, lo_wr_en_ex  in  1 each  HI/LO write enables
- res_mem  out  32  EX/MEM registered ALU result (forwarding)
- mem_dst  out  5  EX/MEM destination
- mem_reg_wr  out  1  EX/MEM write enable
- res_wb  out  32  MEM/WB selected result
- wb_dst  out  5  MEM/WB destination
- wb_reg_wr  out  1  MEM/WB write enable
- PC4_wb, res_hi_wb, res_lo_wb  out  32 each  MEM/WB copies
- link_wb, hi_wr_en_wb, lo_wr_en_wb  out  1 each  MEM/WB copies
- mem_stall  out  1  combinational; holds upstream stages while high

Behaviour:
- Reset: every registered output is 0, the FSM is in IDLE, and mem_stall=0. Memory contents are not cleared.
- EX/MEM register:
  - Captures all *_ex inputs on each rising edge when mem_stall=0.
  - Holds its contents while mem_stall=1.
- Load timing:
  - A load is mem_to_reg=01 in EX/MEM.
  - With LOAD_LATENCY=L>1, FSM IDLE->WAIT on the first cycle of the load, and cnt loads L-1.
  - mem_stall=1 while in WAIT, or while in IDLE with a load present and L>1. cnt decrements each cycle.
  - When cnt reaches 1 the load completes, the FSM returns to IDLE, and mem_stall drops that cycle.
  - A load is therefore in MEM for exactly L cycles.
- Bubbles: while stalled, MEM/WB captures a bubble (wb_reg_wr=0, hi_wr_en_wb=0, lo_wr_en_wb=0). The completing load then enters MEM/WB.
- Stores:
  - Memory is written on the clock edge when mem_wr=1 and the stage is not already in WAIT. Stores never stall.
  - Word store: the word index is alu_to_mem[idx+1:2].
  - Halfword store: writes bytes selected by addr[1] (0 = bytes 1:0, 1 = bytes 3:2).
  - Byte store: writes the byte at addr[1:0]. The byte is little-endian in the word.
  - Unwritten bytes are preserved.
- Load extract: word, halfword, or byte is chosen by the same addr bits. It is sign-extended if sign_zero_ext=1, otherwise zero-extended.
- Result select:
  - res_wb = ALU, load data, or PC4 according to mem_to_reg.
  - If link=1, res_wb = PC4 regardless of mem_to_reg.
- Write suppression: writes to register 0 pass through, and Decode ignores them. wb_reg_wr = wr_reg_en.
- Address wrap: addresses at or beyond DMEM_WORDS*4 wrap modulo the depth.
- Simultaneous store and load in consecutive cycles: the load observes the earlier store (write-before-read ordering via the edge).
- Reset mid-stall: the FSM returns to IDLE, and both pipeline registers clear.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Enabled: adds output misalign_trap (1 bit, registered with MEM/WB).
  - It is set for a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
  - When it is set, the store is suppressed, and wb_reg_wr is forced to 0.
- Disabled: the port is absent, and low address bits are ignored for word and halfword accesses.

Decomposition:
- Shared package (pipeline_pkg):
  - mem_to_reg encoding constants MTR_ALU, MTR_LOAD, MTR_PC4.
  - mem_stage_state_t enum {IDLE, WAIT}.
- One sub-module, data_memory: a byte-enabled synchronous-write, asynchronous-read RAM with a DMEM_WORDS parameter.

Test Plan:
- Store word 0xDEADBEEF at address 0x10, then load word from 0x10 with LOAD_LATENCY=2 -> mem_stall high for 1 cycle, then res_wb=0xDEADBEEF, wb_reg_wr=1.
- Byte store 0x7F at 0x13 over 0x00000000, then signed byte load at 0x13 -> 0x0000007F.
- Repeat with 0x80 at 0x13, signed byte load -> 0xFFFFFF80; unsigned byte load -> 0x00000080.
- Halfword store 0xABCD at 0x22, then unsigned halfword load -> 0x0000ABCD; word load at 0x20 -> 0xABCD0000.
- Link instruction with PC4_ex=0x00400008 and mem_to_reg=00 -> res_wb=0x00400008; hi_wr_en and lo_wr_en pass through 1 cycle later.
- Assert reset during a LOAD_LATENCY=4 stall -> the next cycle has mem_stall=0, all outputs 0, and the FSM in IDLE. With MEM_ALIGN_CHECK_EN defined, a word load at 0x02 -> misalign_trap=1, wb_reg_wr=0.
